freq_bin_accum: RTL and testbench

Downstream consumer of the replica router's registered (index, complex data) stream. Each accepted sample is multiplied by a complex weight and the Q1.15 result is accumulated into one of 2^INDXLEN frequency bins. On a frame-end marker the block flushes its pipeline, then drains every bin in index order over a valid/ready output and clears it, ready for the next frame.

---
 rtl/freq_bin_accum.sv | 193 +++++++++++++++++++
 tb/tb_freq_bin_accum.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_bin_accum.sv
// Complex-weighted accumulation of an indexed sample stream into 2^INDXLEN saturating
// bins. After each frame the bins are drained in index order and cleared.
module freq_bin_accum #(
    parameter int DATALEN = 16,
    parameter int INDXLEN = 6,
    parameter int ACCLEN  = 24
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_last,
    input  logic [INDXLEN-1:0]   in_index,
    input  logic [2*DATALEN-1:0] in_data,
    input  logic [2*DATALEN-1:0] in_wgt,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INDXLEN-1:0]   out_index,
    output logic [2*ACCLEN-1:0]  out_data,
    output logic                 busy
);
    localparam int NBINS   = 1 << INDXLEN;
    localparam int PRODLEN = 2 * DATALEN;

    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;

    state_t               state_q, state_d;
    logic                 flush_cnt_q, flush_cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [INDXLEN-1:0]   out_index_q, out_index_d;
    logic [2*ACCLEN-1:0]  out_data_q, out_data_d;

    logic                 s1_valid_q, s1_valid_d;
    logic [INDXLEN-1:0]   s1_index_q, s1_index_d;
    logic signed [PRODLEN-1:0] s1_prr_q, s1_prr_d;
    logic signed [PRODLEN-1:0] s1_pii_q, s1_pii_d;
    logic signed [PRODLEN-1:0] s1_pri_q, s1_pri_d;
    logic signed [PRODLEN-1:0] s1_pir_q, s1_pir_d;

    logic                 s2_valid_q, s2_valid_d;
    logic [INDXLEN-1:0]   s2_index_q, s2_index_d;
    logic signed [ACCLEN-1:0] s2_re_q, s2_re_d;
    logic signed [ACCLEN-1:0] s2_im_q, s2_im_d;

    logic signed [ACCLEN-1:0] bin_re_q [NBINS];
    logic signed [ACCLEN-1:0] bin_re_d [NBINS];
    logic signed [ACCLEN-1:0] bin_im_q [NBINS];
    logic signed [ACCLEN-1:0] bin_im_d [NBINS];

    logic signed [DATALEN-1:0] ar, ai, br, bi;
    logic signed [PRODLEN:0]   re_full, im_full;
    logic                      accept;
    logic                      drain_beat;

    assign ar = in_data[2*DATALEN-1:DATALEN];
    assign ai = in_data[DATALEN-1:0];
    assign br = in_wgt[2*DATALEN-1:DATALEN];
    assign bi = in_wgt[DATALEN-1:0];

    assign in_ready   = (state_q == ACCUM);
    assign busy       = (state_q != ACCUM);
    assign accept     = in_valid & in_ready;
    assign drain_beat = (state_q == DRAIN) & out_valid_q & out_ready;

    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;

    function automatic logic signed [ACCLEN-1:0] sat_add(
        input logic signed [ACCLEN-1:0] a,
        input logic signed [ACCLEN-1:0] b
    );
        logic signed [ACCLEN:0] s;
        s = (ACCLEN+1)'(a) + (ACCLEN+1)'(b);
        if (s[ACCLEN] != s[ACCLEN-1])
            return s[ACCLEN] ? {1'b1, {(ACCLEN-1){1'b0}}} : {1'b0, {(ACCLEN-1){1'b1}}};
        return s[ACCLEN-1:0];
    endfunction

    always_comb begin
        s1_valid_d = accept;
        s1_index_d = in_index;
        s1_prr_d   = PRODLEN'(ar) * PRODLEN'(br);
        s1_pii_d   = PRODLEN'(ai) * PRODLEN'(bi);
        s1_pri_d   = PRODLEN'(ar) * PRODLEN'(bi);
        s1_pir_d   = PRODLEN'(ai) * PRODLEN'(br);
    end

    // One extra bit keeps the combine exact; the shift floors back to Q1.15 scale.
    always_comb begin
        re_full    = (PRODLEN+1)'(s1_prr_q) - (PRODLEN+1)'(s1_pii_q);
        im_full    = (PRODLEN+1)'(s1_pri_q) + (PRODLEN+1)'(s1_pir_q);
        s2_valid_d = s1_valid_q;
        s2_index_d = s1_index_q;
        s2_re_d    = ACCLEN'(re_full >>> (DATALEN-1));
        s2_im_d    = ACCLEN'(im_full >>> (DATALEN-1));
    end

    always_comb begin
        bin_re_d = bin_re_q;
        bin_im_d = bin_im_q;
        if (s2_valid_q) begin
            bin_re_d[s2_index_q] = sat_add(bin_re_q[s2_index_q], s2_re_q);
            bin_im_d[s2_index_q] = sat_add(bin_im_q[s2_index_q], s2_im_q);
        end
        if (drain_beat) begin
            bin_re_d[out_index_q] = '0;
            bin_im_d[out_index_q] = '0;
        end
    end

    // The drained value is read from the next-state array so a sample landing on
    // the last flush edge is already included in the first beat.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        unique case (state_q)
            ACCUM: begin
                if (accept && in_last) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 1'b0;
                end
            end
            FLUSH: begin
                if (flush_cnt_q) begin
                    state_d     = DRAIN;
                    out_valid_d = 1'b1;
                    out_index_d = '0;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            DRAIN: begin
                if (drain_beat) begin
                    if (&out_index_q) begin
                        state_d     = ACCUM;
                        out_valid_d = 1'b0;
                        out_index_d = '0;
                    end else begin
                        out_index_d = out_index_q + INDXLEN'(1);
                    end
                end
            end
            default: state_d = ACCUM;
        endcase
        out_data_d = out_valid_d ? {bin_re_d[out_index_d], bin_im_d[out_index_d]} : '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ACCUM;
            flush_cnt_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_index_q  <= '0;
            s1_prr_q    <= '0;
            s1_pii_q    <= '0;
            s1_pri_q    <= '0;
            s1_pir_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_index_q  <= '0;
            s2_re_q     <= '0;
            s2_im_q     <= '0;
            for (int i = 0; i < NBINS; i++) begin
                bin_re_q[i] <= '0;
                bin_im_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            s1_valid_q  <= s1_valid_d;
            s1_index_q  <= s1_index_d;
            s1_prr_q    <= s1_prr_d;
            s1_pii_q    <= s1_pii_d;
            s1_pri_q    <= s1_pri_d;
            s1_pir_q    <= s1_pir_d;
            s2_valid_q  <= s2_valid_d;
            s2_index_q  <= s2_index_d;
            s2_re_q     <= s2_re_d;
            s2_im_q     <= s2_im_d;
            bin_re_q    <= bin_re_d;
            bin_im_q    <= bin_im_d;
        end
    end

endmodule

// File: tb/tb_freq_bin_accum.sv
// Testbench for freq_bin_accum: random and directed frames checked against a
// behavioural bin model built from complex arithmetic with per-step saturation.
module tb_freq_bin_accum;
    localparam int DATALEN = 16;
    localparam int INDXLEN = 6;
    localparam int ACCLEN  = 24;
    localparam int NB      = 1 << INDXLEN;
    localparam longint ACC_MAX = (longint'(1) << (ACCLEN-1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) << (ACCLEN-1));
    localparam longint NOBEAT  = 64'h1234_5678_9abc;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_last = 1'b0;
    logic [INDXLEN-1:0]   in_index = '0;
    logic [2*DATALEN-1:0] in_data = '0;
    logic [2*DATALEN-1:0] in_wgt = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [INDXLEN-1:0]   out_index;
    logic [2*ACCLEN-1:0]  out_data;
    logic                 busy;

    int n_checks = 0;
    int n_fail   = 0;

    longint mdl_re [NB];
    longint mdl_im [NB];
    longint got_re [NB];
    longint got_im [NB];
    int     got_beats;
    bit     drain_timeout;
    bit     drain_order_ok;

    freq_bin_accum #(.DATALEN(DATALEN), .INDXLEN(INDXLEN), .ACCLEN(ACCLEN)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_index(in_index), .in_data(in_data), .in_wgt(in_wgt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic longint sat(input longint v);
        if (v > ACC_MAX) return ACC_MAX;
        if (v < ACC_MIN) return ACC_MIN;
        return v;
    endfunction

    function automatic void model_add(input int idx, input logic [31:0] d, input logic [31:0] w);
        longint ar, ai, br, bi, re, im;
        ar = longint'($signed(d[31:16]));
        ai = longint'($signed(d[15:0]));
        br = longint'($signed(w[31:16]));
        bi = longint'($signed(w[15:0]));
        re = (ar * br - ai * bi) >>> (DATALEN-1);
        im = (ar * bi + ai * br) >>> (DATALEN-1);
        mdl_re[idx] = sat(mdl_re[idx] + re);
        mdl_im[idx] = sat(mdl_im[idx] + im);
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NB; i++) begin
            mdl_re[i] = 0;
            mdl_im[i] = 0;
        end
    endfunction

    function automatic void clear_got();
        for (int i = 0; i < NB; i++) begin
            got_re[i] = NOBEAT;
            got_im[i] = NOBEAT;
        end
    endfunction

    // Called at a negedge while the block is accepting; the model follows the sample.
    task automatic drive_cycle(input bit valid, input bit last, input logic [INDXLEN-1:0] idx,
                               input logic [31:0] d, input logic [31:0] w);
        in_valid = valid;
        in_last  = last;
        in_index = idx;
        in_data  = d;
        in_wgt   = w;
        @(posedge clk);
        if (valid) model_add(int'(idx), d, w);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic collect_drain(input int start);
        int cyc;
        int expect_idx;
        drain_timeout  = 1'b0;
        drain_order_ok = 1'b1;
        got_beats      = 0;
        expect_idx     = start;
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!out_valid) begin
            drain_timeout = 1'b1;
            return;
        end
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && cyc < 200) begin
            if (int'(out_index) != expect_idx) drain_order_ok = 1'b0;
            got_re[out_index] = longint'($signed(out_data[2*ACCLEN-1:ACCLEN]));
            got_im[out_index] = longint'($signed(out_data[ACCLEN-1:0]));
            expect_idx++;
            got_beats++;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (out_valid) drain_timeout = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        model_clear();
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (out_index !== '0) begin n_fail++; $display("[TB] FAIL reset_out_index got %0d want 0", out_index); end
        n_checks++;
        if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_out_data got %h want 0", out_data); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single_sample();
        clear_got();
        in_valid = 1'b1; in_last = 1'b1; in_index = 6'd5;
        in_data = 32'h4000_0000; in_wgt = 32'h4000_0000;
        @(posedge clk);
        model_add(5, 32'h4000_0000, 32'h4000_0000);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_flush1 got busy=%b in_ready=%b out_valid=%b want 1 0 0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_flush2 got busy=%b in_ready=%b out_valid=%b want 1 0 0", busy, in_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_index !== '0) begin
            n_fail++; $display("[TB] FAIL single_first_beat got valid=%b index=%0d want 1 0", out_valid, out_index);
        end
        collect_drain(0);
        n_checks++;
        if (drain_timeout || !drain_order_ok || got_beats != NB) begin
            n_fail++; $display("[TB] FAIL single_drain got beats=%0d order_ok=%0d timeout=%0d want %0d 1 0", got_beats, drain_order_ok, drain_timeout, NB);
        end
        n_checks++;
        if (got_re[5] !== 64'sh2000 || got_im[5] !== 0) begin
            n_fail++; $display("[TB] FAIL single_bin5 got re=%0h im=%0h want 2000 0", got_re[5], got_im[5]);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL single_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("[TB] FAIL single_after_drain got in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        model_clear();
    endtask

    task automatic test_complex_product();
        clear_got();
        drive_cycle(1'b1, 1'b1, 6'd0, 32'h4000_4000, 32'h4000_C000);
        collect_drain(0);
        n_checks++;
        if (drain_timeout || got_beats != NB || got_re[0] !== 64'sh4000 || got_im[0] !== 0) begin
            n_fail++; $display("[TB] FAIL complex_single got re=%0h im=%0h beats=%0d want 4000 0 %0d", got_re[0], got_im[0], got_beats, NB);
        end
        model_clear();
        clear_got();
        drive_cycle(1'b1, 1'b0, 6'd0, 32'h4000_4000, 32'h4000_C000);
        drive_cycle(1'b1, 1'b1, 6'd0, 32'h4000_4000, 32'h4000_C000);
        collect_drain(0);
        n_checks++;
        if (drain_timeout || got_beats != NB || got_re[0] !== 64'sh8000 || got_im[0] !== 0) begin
            n_fail++; $display("[TB] FAIL complex_b2b got re=%0h im=%0h beats=%0d want 8000 0 %0d", got_re[0], got_im[0], got_beats, NB);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL complex_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_saturation();
        clear_got();
        for (int k = 0; k < 256; k++)
            drive_cycle(1'b1, k == 255, 6'd63, 32'h8000_0000, 32'h8000_0000);
        collect_drain(0);
        n_checks++;
        if (drain_timeout || got_beats != NB || got_re[63] !== 64'sh7FFFFF || got_im[63] !== 0) begin
            n_fail++; $display("[TB] FAIL saturation_bin63 got re=%0h im=%0h beats=%0d want 7fffff 0 %0d", got_re[63], got_im[63], got_beats, NB);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL saturation_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
    endtask

    // Random frames include idle cycles carrying a stray in_last that must be ignored.
    task automatic test_random();
        for (int f = 0; f < 2; f++) begin
            int n;
            clear_got();
            n = int'($urandom_range(20, 60));
            for (int k = 0; k < n; k++) begin
                bit v, l;
                v = (k == n-1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                l = (k == n-1) ? 1'b1 : (v ? 1'b0 : 1'($urandom_range(0, 1)));
                drive_cycle(v, l, INDXLEN'($urandom_range(0, NB-1)), $urandom(), $urandom());
            end
            collect_drain(0);
            n_checks++;
            if (drain_timeout || !drain_order_ok || got_beats != NB) begin
                n_fail++; $display("[TB] FAIL random_drain%0d got beats=%0d order_ok=%0d timeout=%0d want %0d 1 0", f, got_beats, drain_order_ok, drain_timeout, NB);
            end
            for (int i = 0; i < NB; i++) begin
                n_checks++;
                if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                    n_fail++; $display("[TB] FAIL random%0d_bin%0d got re=%0d im=%0d want re=%0d im=%0d", f, i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
                end
            end
            model_clear();
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        clear_got();
        drive_cycle(1'b1, 1'b0, 6'd3, $urandom(), $urandom());
        drive_cycle(1'b1, 1'b0, 6'd1, $urandom(), $urandom());
        drive_cycle(1'b1, 1'b1, 6'd3, $urandom(), $urandom());
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        out_ready = 1'b1;
        cyc = 0;
        while (out_valid && out_index != 6'd3 && cyc < 10) begin
            got_re[out_index] = longint'($signed(out_data[2*ACCLEN-1:ACCLEN]));
            got_im[out_index] = longint'($signed(out_data[ACCLEN-1:0]));
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_index !== 6'd3 || in_ready !== 1'b0 ||
                longint'($signed(out_data[2*ACCLEN-1:ACCLEN])) !== mdl_re[3] ||
                longint'($signed(out_data[ACCLEN-1:0])) !== mdl_im[3]) begin
                n_fail++; $display("[TB] FAIL backpressure_hold%0d got valid=%b index=%0d in_ready=%b data=%h want 1 3 0 re=%0d im=%0d", c, out_valid, out_index, in_ready, out_data, mdl_re[3], mdl_im[3]);
            end
        end
        collect_drain(3);
        n_checks++;
        if (drain_timeout || !drain_order_ok || got_beats != NB-3) begin
            n_fail++; $display("[TB] FAIL backpressure_resume got beats=%0d order_ok=%0d timeout=%0d want %0d 1 0", got_beats, drain_order_ok, drain_timeout, NB-3);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL backpressure_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
        clear_got();
        drive_cycle(1'b1, 1'b0, 6'd40, $urandom(), $urandom());
        drive_cycle(1'b1, 1'b1, 6'd7, $urandom(), $urandom());
        collect_drain(0);
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL backpressure_next_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_mid_drain_reset();
        int cyc;
        for (int k = 0; k < 10; k++)
            drive_cycle(1'b1, k == 9, INDXLEN'($urandom_range(0, NB-1)), $urandom(), $urandom());
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(negedge clk); cyc++; end
        out_ready = 1'b1;
        cyc = 0;
        while (out_index != 6'd20 && cyc < 40) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (out_index !== 6'd20 || out_valid !== 1'b1) begin
            n_fail++; $display("[TB] FAIL midreset_reach20 got index=%0d valid=%b want 20 1", out_index, out_valid);
        end
        rstn = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_index !== '0) begin
            n_fail++; $display("[TB] FAIL midreset_outputs got valid=%b busy=%b in_ready=%b index=%0d want 0 0 1 0", out_valid, busy, in_ready, out_index);
        end
        out_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        model_clear();
        clear_got();
        drive_cycle(1'b1, 1'b1, 6'd9, $urandom(), $urandom());
        collect_drain(0);
        n_checks++;
        if (drain_timeout || got_beats != NB) begin
            n_fail++; $display("[TB] FAIL midreset_drain got beats=%0d timeout=%0d want %0d 0", got_beats, drain_timeout, NB);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL midreset_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
    endtask

    task automatic test_frame_boundary();
        clear_got();
        for (int k = 0; k < 6; k++)
            drive_cycle(1'b1, k == 5, INDXLEN'($urandom_range(0, NB-1)), $urandom(), $urandom());
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_last  = 1'($urandom_range(0, 1));
            in_index = INDXLEN'($urandom_range(0, NB-1));
            in_data  = $urandom();
            in_wgt   = $urandom();
            n_checks++;
            if (in_ready !== 1'b0) begin
                n_fail++; $display("[TB] FAIL boundary_in_ready%0d got %b want 0", c, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        collect_drain(0);
        n_checks++;
        if (drain_timeout || !drain_order_ok || got_beats != NB) begin
            n_fail++; $display("[TB] FAIL boundary_drain got beats=%0d order_ok=%0d timeout=%0d want %0d 1 0", got_beats, drain_order_ok, drain_timeout, NB);
        end
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (got_re[i] !== mdl_re[i] || got_im[i] !== mdl_im[i]) begin
                n_fail++; $display("[TB] FAIL boundary_bin%0d got re=%0d im=%0d want re=%0d im=%0d", i, got_re[i], got_im[i], mdl_re[i], mdl_im[i]);
            end
        end
        model_clear();
    endtask

    initial begin
        test_reset();
        test_single_sample();
        test_complex_product();
        test_saturation();
        test_random();
        test_backpressure();
        test_mid_drain_reset();
        test_frame_boundary();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
